// File: rtl/squash_score_keeper.sv
// Right-player score keeper for the squash display: conditions the serve button,
// runs the IDLE/RALLY/HOLD/GAME_OVER match FSM and drives score, state and launch strobe.

module squash_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic         s1, s2, lvl, lvl_q;
  logic [W-1:0] cnt;

  // The accepted level only moves after CYCLES consecutive edges of disagreement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_q <= lvl;
      if (s2 != lvl) begin
        if (cnt == LAST) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = lvl & ~lvl_q;
endmodule

module squash_score_keeper #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int WIN_SCORE       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serve_btn,
  input  logic       point_in,
  input  logic       fault_in,
  output logic [1:0] rightpscore,
  output logic       gamestate,
  output logic       ball_launch,
  output logic       game_over
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    WIN       = 2'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, RALLY, HOLD, GAME_OVER} state_t;

  state_t          state_q, state_d;
  logic [1:0]      score_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            launch_d;
  logic            serve_press;

  squash_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock (clock),
    .reset (reset),
    .btn   (serve_btn),
    .press (serve_press)
  );

  always_comb begin
    state_d  = state_q;
    score_d  = rightpscore;
    hold_d   = hold_q;
    launch_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (serve_press) begin
          state_d  = RALLY;
          launch_d = 1'b1;
        end
      end
      RALLY: begin
        // A point outranks a simultaneous fault.
        if (point_in) begin
          score_d = rightpscore + 2'd1;
          hold_d  = '0;
          state_d = (score_d == WIN) ? GAME_OVER : HOLD;
        end else if (fault_in) begin
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = IDLE;
        else                     hold_d  = hold_q + 1'b1;
      end
      GAME_OVER: begin
        if (serve_press) begin
          score_d = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rightpscore <= 2'd0;
      gamestate   <= 1'b0;
      ball_launch <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rightpscore <= score_d;
      gamestate   <= (state_d == RALLY);
      ball_launch <= launch_d;
      game_over   <= (state_d == GAME_OVER);
    end
  end
endmodule

// File: tb/tb_squash_score_keeper.sv
// Directed bench for squash_score_keeper with a per-cycle behavioural match model.

module tb_squash_score_keeper;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int WIN  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       serve_btn = 1'b0;
  logic       point_in = 1'b0;
  logic       fault_in = 1'b0;
  logic [1:0] rightpscore;
  logic       gamestate, ball_launch, game_over;

  int n_chk = 0;
  int n_fail = 0;
  int n_launch = 0;

  squash_score_keeper #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .WIN_SCORE(WIN)) dut (
    .clock       (clock),
    .reset       (reset),
    .serve_btn   (serve_btn),
    .point_in    (point_in),
    .fault_in    (fault_in),
    .rightpscore (rightpscore),
    .gamestate   (gamestate),
    .ball_launch (ball_launch),
    .game_over   (game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Match model: 0 idle, 1 ball live, 2 post-rally pause, 3 game over.
  int mode = 0, score = 0, hold_left = 0, run = 0;
  bit b_sync1 = 0, b_sync2 = 0, b_acc = 0, press_due = 0;
  bit exp_launch = 0;

  initial begin
    forever begin
      @(posedge clock);
      if (!reset) begin
        mode = 0; score = 0; hold_left = 0; run = 0;
        b_sync1 = 0; b_sync2 = 0; b_acc = 0; press_due = 0; exp_launch = 0;
      end else begin
        exp_launch = 0;
        case (mode)
          0: if (press_due) begin mode = 1; exp_launch = 1; end
          1: begin
            if (point_in) begin
              score = score + 1;
              mode = (score == WIN) ? 3 : 2;
              hold_left = HOLD;
            end else if (fault_in) begin
              mode = 2;
              hold_left = HOLD;
            end
          end
          2: if (hold_left == 1) mode = 0; else hold_left = hold_left - 1;
          default: if (press_due) begin score = 0; mode = 0; end
        endcase
        // Button: accepted level follows the synced level after DEB differing edges.
        press_due = 0;
        if (b_sync2 != b_acc) begin
          run = run + 1;
          if (run == DEB) begin
            b_acc = b_sync2;
            run = 0;
            press_due = b_acc;
          end
        end else begin
          run = 0;
        end
        b_sync2 = b_sync1;
        b_sync1 = serve_btn;
      end
      #1;
      chk("score", rightpscore, score);
      chk("gamestate", gamestate, int'(mode == 1));
      chk("game_over", game_over, int'(mode == 3));
      chk("ball_launch", ball_launch, int'(exp_launch));
      if (ball_launch) n_launch++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic serve();
    serve_btn = 1'b1;
    cycles(10);
    serve_btn = 1'b0;
    cycles(8);
  endtask

  task automatic pulse(input bit p, input bit f);
    @(negedge clock);
    point_in = p;
    fault_in = f;
    @(negedge clock);
    point_in = 1'b0;
    fault_in = 1'b0;
  endtask

  int l0;

  initial begin
    // Reset with inputs wiggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      serve_btn = ~serve_btn;
      point_in  = ~point_in;
      fault_in  = ~fault_in;
      chk("rst_score", rightpscore, 0);
      chk("rst_gs", gamestate, 0);
    end
    serve_btn = 1'b0; point_in = 1'b0; fault_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Clean press
    serve_btn = 1'b1;
    cycles(10);
    chk("first_launch_count", n_launch, 1);
    chk("first_gs", gamestate, 1);
    serve_btn = 1'b0;
    cycles(8);
    pulse(0, 1);
    cycles(10);
    chk("after_fault_idle_gs", gamestate, 0);

    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      serve_btn = ~serve_btn;
      cycles(2);
    end
    chk("bounce_no_launch", n_launch, 1);
    chk("bounce_gs", gamestate, 0);
    serve_btn = 1'b1;
    cycles(10);
    chk("stable_launch", n_launch, 2);
    chk("stable_gs", gamestate, 1);
    serve_btn = 1'b0;
    cycles(8);

    // Point, press ignored during pause, then fault
    pulse(1, 0);
    chk("point_score", rightpscore, 1);
    chk("point_gs", gamestate, 0);
    serve_btn = 1'b1;
    cycles(6);
    serve_btn = 1'b0;
    cycles(2);
    chk("hold_press_ignored", n_launch, 2);
    cycles(8);
    serve();
    chk("serve_after_hold", n_launch, 3);
    pulse(0, 1);
    chk("fault_score", rightpscore, 1);
    cycles(10);

    // Simultaneous point + fault
    serve();
    pulse(1, 1);
    chk("simul_score", rightpscore, 2);
    chk("simul_gs", gamestate, 0);
    cycles(10);

    // Game over
    serve();
    pulse(1, 0);
    chk("win_score", rightpscore, 3);
    chk("win_over", game_over, 1);
    chk("win_gs", gamestate, 0);
    pulse(1, 0);
    pulse(1, 0);
    chk("frozen_score", rightpscore, 3);
    l0 = n_launch;
    serve();
    chk("restart_no_launch", n_launch, l0);
    chk("restart_score", rightpscore, 0);
    chk("restart_over", game_over, 0);
    serve();
    chk("serve_after_restart", n_launch, l0 + 1);
    chk("serve_after_restart_gs", gamestate, 1);

    // Build score 2 then reset mid-rally between edges
    pulse(1, 0);
    cycles(10);
    serve();
    pulse(1, 0);
    cycles(10);
    serve();
    chk("pre_reset_score", rightpscore, 2);
    chk("pre_reset_gs", gamestate, 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_score", rightpscore, 0);
    chk("async_rst_gs", gamestate, 0);
    chk("async_rst_over", game_over, 0);
    cycles(2);
    reset = 1'b1;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
